// File: rtl/instr_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_ctrl_unit
// Description : Multi-cycle fetch/decode/control sequencer for an 8x8 register
//               file plus ALU datapath. Fetches 32-bit instructions over a
//               valid handshake, holds the PC, decodes register addresses,
//               write enable, ALU operation and operand-mux selects, and
//               resolves jumps and branches using the ALU zero flag.
//
// Ports       : CLK          rising-edge clock
//               RESET        synchronous active-high reset
//               INSTR        instruction word from instruction memory
//               INSTR_VALID  INSTR valid (only looked at in FETCH)
//               ZERO         ALU zero flag (captured at the end of EXEC)
//               INSTR_REQ    fetch request, high throughout FETCH
//               PC           byte address of the current instruction
//               INADDRESS    register-file write address
//               OUT1ADDRESS  register-file read port 1 address (rt)
//               OUT2ADDRESS  register-file read port 2 address (rs)
//               WRITE        register-file write enable, one-cycle pulse in WB
//               ALUOP        000 FWD, 001 ADD, 010 AND, 011 OR
//               IMMEDIATE    8-bit immediate operand
//               IMM_SEL      ALU operand 2 taken from IMMEDIATE
//               NEG_SEL      ALU operand 2 two's-complement negated
//               ILLEGAL      sticky undefined-opcode flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_ctrl_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    input  logic        ZERO,
    output logic        INSTR_REQ,
    output logic [31:0] PC,
    output logic [2:0]  INADDRESS,
    output logic [2:0]  OUT1ADDRESS,
    output logic [2:0]  OUT2ADDRESS,
    output logic        WRITE,
    output logic [2:0]  ALUOP,
    output logic [7:0]  IMMEDIATE,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic        ILLEGAL
);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FWD  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [7:0]  op_q;        // opcode of the instruction in flight
    logic [7:0]  off_q;       // signed word offset for j/beq
    logic        wr_en_q;     // instruction in flight writes the register file
    logic        zero_q;      // ZERO captured at the EXEC->WB edge
    logic        instr_req_q;
    logic        write_q;
    logic        illegal_q;
    logic [31:0] pc_q;
    logic [2:0]  in_addr_q, out1_addr_q, out2_addr_q, aluop_q;
    logic [7:0]  imm_q;
    logic        imm_sel_q, neg_sel_q;

    // Decode of the incoming word; only consumed on the FETCH->DECODE edge.
    logic [2:0]  dec_aluop;
    logic        dec_imm_sel, dec_neg_sel, dec_write, dec_illegal;

    logic [31:0] pc_plus4, pc_branch, pc_d;
    logic        take_branch;

    // Bits [15:11] of the source-1 field are not part of any register address.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^INSTR[15:11];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (INSTR_VALID) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end

    // ------------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------------
    always_comb begin
        dec_aluop   = ALU_FWD;
        dec_imm_sel = 1'b0;
        dec_neg_sel = 1'b0;
        dec_write   = 1'b0;
        dec_illegal = 1'b0;
        case (INSTR[31:24])
            OP_LOADI: begin dec_imm_sel = 1'b1; dec_write = 1'b1; end
            OP_MOV:   begin dec_write = 1'b1; end
            OP_ADD:   begin dec_aluop = ALU_ADD; dec_write = 1'b1; end
            OP_SUB:   begin dec_aluop = ALU_ADD; dec_neg_sel = 1'b1; dec_write = 1'b1; end
            OP_AND:   begin dec_aluop = ALU_AND; dec_write = 1'b1; end
            OP_OR:    begin dec_aluop = ALU_OR;  dec_write = 1'b1; end
            OP_J:     begin end
            // beq compares rt and rs by subtracting them in the ALU
            OP_BEQ:   begin dec_aluop = ALU_ADD; dec_neg_sel = 1'b1; end
            default:  begin dec_illegal = 1'b1; end
        endcase
    end

    // ------------------------------------------------------------------------
    // PC update: offset is in words, so sign-extend and scale by 4.
    // ------------------------------------------------------------------------
    assign pc_plus4    = pc_q + 32'd4;
    assign pc_branch   = pc_plus4 + {{22{off_q[7]}}, off_q, 2'b00};
    assign take_branch = (op_q == OP_J) || ((op_q == OP_BEQ) && zero_q);
    assign pc_d        = take_branch ? pc_branch : pc_plus4;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_RST;
            op_q        <= 8'h00;
            off_q       <= 8'h00;
            wr_en_q     <= 1'b0;
            zero_q      <= 1'b0;
            instr_req_q <= 1'b0;
            write_q     <= 1'b0;
            illegal_q   <= 1'b0;
            pc_q        <= 32'h0;
            in_addr_q   <= 3'd0;
            out1_addr_q <= 3'd0;
            out2_addr_q <= 3'd0;
            aluop_q     <= ALU_FWD;
            imm_q       <= 8'h00;
            imm_sel_q   <= 1'b0;
            neg_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Registered from the next state so the request is high for
            // exactly the cycles spent in FETCH.
            instr_req_q <= (state_d == S_FETCH);
            // Pulse lands in WB only for register-writing instructions.
            write_q     <= (state_q == S_EXEC) && wr_en_q;

            if ((state_q == S_FETCH) && INSTR_VALID) begin
                op_q        <= INSTR[31:24];
                off_q       <= INSTR[23:16];
                in_addr_q   <= INSTR[18:16];
                out1_addr_q <= INSTR[10:8];
                out2_addr_q <= INSTR[2:0];
                imm_q       <= INSTR[7:0];
                aluop_q     <= dec_aluop;
                imm_sel_q   <= dec_imm_sel;
                neg_sel_q   <= dec_neg_sel;
                wr_en_q     <= dec_write;
                if (dec_illegal) begin
                    illegal_q <= 1'b1;
                end
            end

            if (state_q == S_EXEC) begin
                zero_q <= ZERO;
            end

            if (state_q == S_WB) begin
                pc_q <= pc_d;
            end
        end
    end

    assign INSTR_REQ   = instr_req_q;
    assign PC          = pc_q;
    assign INADDRESS   = in_addr_q;
    assign OUT1ADDRESS = out1_addr_q;
    assign OUT2ADDRESS = out2_addr_q;
    assign WRITE       = write_q;
    assign ALUOP       = aluop_q;
    assign IMMEDIATE   = imm_q;
    assign IMM_SEL     = imm_sel_q;
    assign NEG_SEL     = neg_sel_q;
    assign ILLEGAL     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_ctrl_unit
// Description : Self-checking bench for instr_ctrl_unit. Directed scenarios
//               plus a random instruction stream compared against a
//               behavioural model of the instruction set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_ctrl_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        ZERO;
    logic        INSTR_REQ;
    logic [31:0] PC;
    logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP;
    logic        WRITE;
    logic [7:0]  IMMEDIATE;
    logic        IMM_SEL, NEG_SEL, ILLEGAL;

    int tests = 0;
    int fails = 0;

    instr_ctrl_unit dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .ZERO(ZERO), .INSTR_REQ(INSTR_REQ), .PC(PC), .INADDRESS(INADDRESS),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .WRITE(WRITE),
        .ALUOP(ALUOP), .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL),
        .NEG_SEL(NEG_SEL), .ILLEGAL(ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model state ----------------
    logic [31:0] model_pc;
    logic        model_ill;
    logic [31:0] exp_fetch_pc, exp_next_pc;
    logic [2:0]  exp_in, exp_o1, exp_o2, exp_alu;
    logic [7:0]  exp_imm;
    logic        exp_immsel, exp_negsel, exp_wr;

    // ---------------- observations of one instruction ----------------
    logic [31:0] o_fetch_pc, o_next_pc;
    logic [2:0]  o_in, o_o1, o_o2, o_alu;
    logic [7:0]  o_imm;
    logic        o_immsel, o_negsel, o_wr_wb, o_wr_else, o_req_ok, o_pc_stable;
    logic        o_hold_ok, o_ill, o_next_req;
    int          o_cycles;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Instruction-set semantics: which fields matter and how the PC moves.
    task automatic model_instr(input logic [31:0] ins, input logic z);
        logic [7:0] op;
        int         woff;
        op           = ins[31:24];
        woff         = $signed(ins[23:16]);
        exp_fetch_pc = model_pc;
        exp_in       = ins[18:16];
        exp_o1       = ins[10:8];
        exp_o2       = ins[2:0];
        exp_imm      = ins[7:0];
        exp_immsel   = (op == 8'd0);
        exp_negsel   = (op == 8'd3) || (op == 8'd7);
        exp_wr       = (op <= 8'd5);
        case (op)
            8'd2, 8'd3, 8'd7: exp_alu = 3'd1;
            8'd4:             exp_alu = 3'd2;
            8'd5:             exp_alu = 3'd3;
            default:          exp_alu = 3'd0;
        endcase
        if (op > 8'd7) model_ill = 1'b1;
        if ((op == 8'd6) || ((op == 8'd7) && z))
            model_pc = model_pc + 32'd4 + 32'(woff * 4);
        else
            model_pc = model_pc + 32'd4;
        exp_next_pc = model_pc;
    endtask

    // Drives one instruction starting in FETCH and captures what the DUT did
    // up to the following FETCH. Also advances the model.
    task automatic exec_instr(input logic [31:0] ins, input int stall, input logic z);
        model_instr(ins, z);
        o_fetch_pc  = PC;
        o_req_ok    = INSTR_REQ;
        o_wr_else   = WRITE;
        o_wr_wb     = 1'b0;
        o_pc_stable = 1'b1;
        o_cycles    = 0;
        INSTR_VALID = 1'b0;
        for (int i = 0; i < stall; i++) begin
            INSTR = $urandom;
            step();
            o_cycles++;
            if (INSTR_REQ !== 1'b1) o_req_ok = 1'b0;
            if (WRITE !== 1'b0) o_wr_else = 1'b1;
            if (PC !== o_fetch_pc) o_pc_stable = 1'b0;
        end
        INSTR = ins;
        INSTR_VALID = 1'b1;
        step();                                   // now DECODE
        o_cycles++;
        INSTR = $urandom;                         // ignored outside FETCH
        INSTR_VALID = 1'($urandom);
        if (WRITE !== 1'b0) o_wr_else = 1'b1;
        if (PC !== o_fetch_pc) o_pc_stable = 1'b0;
        step();                                   // now EXEC
        o_cycles++;
        ZERO = z;
        o_in = INADDRESS; o_o1 = OUT1ADDRESS; o_o2 = OUT2ADDRESS; o_alu = ALUOP;
        o_imm = IMMEDIATE; o_immsel = IMM_SEL; o_negsel = NEG_SEL;
        if (WRITE !== 1'b0) o_wr_else = 1'b1;
        if (PC !== o_fetch_pc) o_pc_stable = 1'b0;
        INSTR_VALID = 1'($urandom);
        step();                                   // now WB
        o_cycles++;
        ZERO = 1'($urandom);
        o_wr_wb = WRITE;
        if (PC !== o_fetch_pc) o_pc_stable = 1'b0;
        o_hold_ok = (INADDRESS === o_in) && (OUT1ADDRESS === o_o1) && (OUT2ADDRESS === o_o2)
                 && (ALUOP === o_alu) && (IMMEDIATE === o_imm) && (IMM_SEL === o_immsel)
                 && (NEG_SEL === o_negsel);
        INSTR_VALID = 1'($urandom);
        step();                                   // back in FETCH
        o_cycles++;
        INSTR_VALID = 1'b0;
        o_next_pc  = PC;
        o_next_req = INSTR_REQ;
        o_ill      = ILLEGAL;
        if (WRITE !== 1'b0) o_wr_else = 1'b1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        INSTR_VALID = 1'b0;
        step();
        step();
        RESET = 1'b0;
        step();
        model_pc  = 32'h0;
        model_ill = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b1;
        INSTR_VALID = 1'b1;
        INSTR = 32'h0003002A;
        ZERO = 1'b0;
        step();
        step();
        RESET = 1'b0;
        INSTR_VALID = 1'b0;
        tests++; if (PC !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 00000000", PC); end
        tests++; if ({INSTR_REQ, WRITE, IMM_SEL, NEG_SEL, ILLEGAL} !== 5'b0) begin fails++;
            $display("FAIL reset_flags got %b exp 00000", {INSTR_REQ, WRITE, IMM_SEL, NEG_SEL, ILLEGAL}); end
        tests++; if ({INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP, IMMEDIATE} !== 20'h0) begin fails++;
            $display("FAIL reset_fields got %h exp 00000", {INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP, IMMEDIATE}); end
        step();
        tests++; if (INSTR_REQ !== 1'b1) begin fails++; $display("FAIL first_fetch_req got %b exp 1", INSTR_REQ); end
        model_pc  = 32'h0;
        model_ill = 1'b0;
    endtask

    task automatic test_loadi();
        exec_instr(32'h0003002A, 0, 1'b0);
        tests++; if (o_fetch_pc !== 32'h0) begin fails++; $display("FAIL loadi_fetch_pc got %h exp 00000000", o_fetch_pc); end
        tests++; if (o_in !== 3'd3) begin fails++; $display("FAIL loadi_inaddr got %0d exp 3", o_in); end
        tests++; if (o_imm !== 8'h2A) begin fails++; $display("FAIL loadi_imm got %h exp 2a", o_imm); end
        tests++; if (o_immsel !== 1'b1) begin fails++; $display("FAIL loadi_immsel got %b exp 1", o_immsel); end
        tests++; if (o_alu !== 3'd0) begin fails++; $display("FAIL loadi_aluop got %0d exp 0", o_alu); end
        tests++; if ({o_wr_wb, o_wr_else} !== 2'b10) begin fails++; $display("FAIL loadi_write got wb=%b else=%b exp wb=1 else=0", o_wr_wb, o_wr_else); end
        tests++; if (o_next_pc !== 32'h4) begin fails++; $display("FAIL loadi_next_pc got %h exp 00000004", o_next_pc); end
        tests++; if (o_cycles !== 4) begin fails++; $display("FAIL loadi_latency got %0d exp 4", o_cycles); end
    endtask

    task automatic test_stall();
        exec_instr(32'h02010204, 5, 1'b0);
        tests++; if (o_req_ok !== 1'b1) begin fails++; $display("FAIL stall_req got %b exp 1", o_req_ok); end
        tests++; if ({o_o1, o_o2, o_in} !== {3'd2, 3'd4, 3'd1}) begin fails++;
            $display("FAIL stall_addr got o1=%0d o2=%0d in=%0d exp 2 4 1", o_o1, o_o2, o_in); end
        tests++; if (o_alu !== 3'd1) begin fails++; $display("FAIL stall_aluop got %0d exp 1", o_alu); end
        tests++; if (o_cycles !== 9) begin fails++; $display("FAIL stall_latency got %0d exp 9", o_cycles); end
        tests++; if (o_next_pc !== 32'h8) begin fails++; $display("FAIL stall_next_pc got %h exp 00000008", o_next_pc); end
    endtask

    task automatic test_branch();
        exec_instr(32'h04010203, 0, 1'b1);        // and
        exec_instr(32'h05020304, 1, 1'b0);        // or
        tests++; if (PC !== 32'h10) begin fails++; $display("FAIL branch_setup_pc got %h exp 00000010", PC); end
        exec_instr(32'h07FE0102, 0, 1'b1);
        tests++; if (o_next_pc !== 32'h0C) begin fails++; $display("FAIL beq_taken_pc got %h exp 0000000c", o_next_pc); end
        tests++; if ({o_wr_wb, o_wr_else} !== 2'b00) begin fails++; $display("FAIL beq_taken_write got wb=%b else=%b exp 0 0", o_wr_wb, o_wr_else); end
        tests++; if ({o_negsel, o_alu} !== 4'b1001) begin fails++; $display("FAIL beq_ctrl got neg=%b alu=%0d exp 1 1", o_negsel, o_alu); end
        exec_instr(32'h01040005, 0, 1'b1);        // mov
        exec_instr(32'h07FE0102, 2, 1'b0);
        tests++; if (o_fetch_pc !== 32'h10) begin fails++; $display("FAIL beq_nt_fetch_pc got %h exp 00000010", o_fetch_pc); end
        tests++; if (o_next_pc !== 32'h14) begin fails++; $display("FAIL beq_not_taken_pc got %h exp 00000014", o_next_pc); end
        tests++; if ({o_wr_wb, o_wr_else} !== 2'b00) begin fails++; $display("FAIL beq_nt_write got wb=%b else=%b exp 0 0", o_wr_wb, o_wr_else); end
    endtask

    task automatic test_jump_wrap();
        do_reset();
        exec_instr(32'h06FE0000, 0, 1'b0);        // j -2 from 0
        tests++; if (o_next_pc !== 32'hFFFFFFFC) begin fails++; $display("FAIL j_back_pc got %h exp fffffffc", o_next_pc); end
        exec_instr(32'h06010000, 0, 1'b1);        // j +1 from 0xFFFFFFFC
        tests++; if (o_next_pc !== 32'h00000004) begin fails++; $display("FAIL j_wrap_pc got %h exp 00000004", o_next_pc); end
        tests++; if ({o_wr_wb, o_wr_else} !== 2'b00) begin fails++; $display("FAIL j_write got wb=%b else=%b exp 0 0", o_wr_wb, o_wr_else); end
        exec_instr(32'h03050607, 0, 1'b0);        // sub
        tests++; if ({o_negsel, o_alu, o_immsel} !== 5'b10010) begin fails++;
            $display("FAIL sub_ctrl got neg=%b alu=%0d imm_sel=%b exp 1 1 0", o_negsel, o_alu, o_immsel); end
        tests++; if (o_wr_wb !== 1'b1) begin fails++; $display("FAIL sub_write got %b exp 1", o_wr_wb); end
    endtask

    task automatic test_illegal();
        logic [31:0] pc0;
        pc0 = PC;
        exec_instr(32'hFF123456, 0, 1'b1);
        tests++; if (o_ill !== 1'b1) begin fails++; $display("FAIL illegal_flag got %b exp 1", o_ill); end
        tests++; if ({o_wr_wb, o_wr_else} !== 2'b00) begin fails++; $display("FAIL illegal_write got wb=%b else=%b exp 0 0", o_wr_wb, o_wr_else); end
        tests++; if (o_next_pc !== pc0 + 32'd4) begin fails++; $display("FAIL illegal_pc got %h exp %h", o_next_pc, pc0 + 32'd4); end
        exec_instr(32'h00010011, 0, 1'b0);
        exec_instr(32'h02020304, 0, 1'b0);
        tests++; if (o_ill !== 1'b1) begin fails++; $display("FAIL illegal_sticky got %b exp 1", o_ill); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int          stall;
        logic        z;
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) == 0) ins[31:24] = 8'(8 + $urandom_range(0, 247));
            else                           ins[31:24] = 8'($urandom_range(0, 7));
            stall = $urandom_range(0, 3);
            z     = 1'($urandom);
            exec_instr(ins, stall, z);
            tests++; if (o_fetch_pc !== exp_fetch_pc) begin fails++; $display("FAIL rnd%0d_fetch_pc got %h exp %h", n, o_fetch_pc, exp_fetch_pc); end
            tests++; if ({o_in, o_o1, o_o2} !== {exp_in, exp_o1, exp_o2}) begin fails++;
                $display("FAIL rnd%0d_addr ins=%h got %0d %0d %0d exp %0d %0d %0d", n, ins, o_in, o_o1, o_o2, exp_in, exp_o1, exp_o2); end
            tests++; if ({o_alu, o_imm, o_immsel, o_negsel} !== {exp_alu, exp_imm, exp_immsel, exp_negsel}) begin fails++;
                $display("FAIL rnd%0d_ctrl ins=%h got alu=%0d imm=%h is=%b ns=%b exp alu=%0d imm=%h is=%b ns=%b", n, ins,
                         o_alu, o_imm, o_immsel, o_negsel, exp_alu, exp_imm, exp_immsel, exp_negsel); end
            tests++; if ({o_wr_wb, o_wr_else} !== {exp_wr, 1'b0}) begin fails++;
                $display("FAIL rnd%0d_write ins=%h got wb=%b else=%b exp wb=%b else=0", n, ins, o_wr_wb, o_wr_else, exp_wr); end
            tests++; if (o_next_pc !== exp_next_pc) begin fails++; $display("FAIL rnd%0d_next_pc ins=%h z=%b got %h exp %h", n, ins, z, o_next_pc, exp_next_pc); end
            tests++; if (o_cycles !== stall + 4) begin fails++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, o_cycles, stall + 4); end
            tests++; if ({o_req_ok, o_next_req, o_pc_stable, o_hold_ok} !== 4'b1111) begin fails++;
                $display("FAIL rnd%0d_stability got req=%b next_req=%b pc=%b hold=%b exp 1111", n, o_req_ok, o_next_req, o_pc_stable, o_hold_ok); end
            tests++; if (o_ill !== model_ill) begin fails++; $display("FAIL rnd%0d_illegal got %b exp %b", n, o_ill, model_ill); end
        end
    endtask

    task automatic test_reset_mid();
        logic sticky;
        sticky = ILLEGAL;
        tests++; if (sticky !== 1'b1) begin fails++; $display("FAIL pre_reset_illegal got %b exp 1", sticky); end
        INSTR = 32'h02010204;
        INSTR_VALID = 1'b1;
        step();                                   // DECODE
        INSTR_VALID = 1'b0;
        step();                                   // EXEC
        RESET = 1'b1;
        step();
        tests++; if (WRITE !== 1'b0) begin fails++; $display("FAIL midrst_write got %b exp 0", WRITE); end
        tests++; if ({PC, ILLEGAL, INSTR_REQ} !== 34'h0) begin fails++;
            $display("FAIL midrst_state got pc=%h ill=%b req=%b exp 0 0 0", PC, ILLEGAL, INSTR_REQ); end
        RESET = 1'b0;
        step();
        tests++; if ({WRITE, INSTR_REQ, PC} !== {2'b01, 32'h0}) begin fails++;
            $display("FAIL post_rst_fetch got wr=%b req=%b pc=%h exp 0 1 00000000", WRITE, INSTR_REQ, PC); end
    endtask

    initial begin
        RESET = 1'b1;
        INSTR = 32'h0;
        INSTR_VALID = 1'b0;
        ZERO = 1'b0;
        model_pc = 32'h0;
        model_ill = 1'b0;
        test_reset();
        test_loadi();
        test_stall();
        test_branch();
        test_jump_wrap();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_ctrl_unit.md
# instr_ctrl_unit

Multi-cycle fetch/decode/control sequencer that sits directly upstream of the 8×8 register file and the ALU. It requests 32-bit instructions from instruction memory over a valid handshake and holds the program counter. It decodes each instruction into register-file read/write addresses, the write enable, ALU operation and operand-mux selects. It also resolves jumps and branches using the ALU zero flag.

## Interface
- No parameters; all widths fixed.
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- INSTR  input  32  instruction word from instruction memory
- INSTR_VALID  input  1  INSTR valid this cycle; sampled only in FETCH
- ZERO  input  1  ALU result-is-zero flag, sampled in EXEC
- INSTR_REQ  output  1  fetch request, high throughout FETCH
- PC  output  32  byte address of instruction being fetched/executed
- INADDRESS  output  3  register-file write address
- OUT1ADDRESS  output  3  register-file read port 1 address
- OUT2ADDRESS  output  3  register-file read port 2 address
- WRITE  output  1  register-file write enable, one-cycle pulse
- ALUOP  output  3  000 FWD, 001 ADD, 010 AND, 011 OR
- IMMEDIATE  output  8  immediate operand
- IMM_SEL  output  1  1 = ALU operand 2 is IMMEDIATE
- NEG_SEL  output  1  1 = ALU operand 2 is two's-complement negated
- ILLEGAL  output  1  sticky flag, undefined opcode seen

## Operation
- Instruction fields:
  - [31:24] opcode
  - [23:16] destination or signed word offset
  - [15:8] source 1 (rt)
  - [7:0] source 2 (rs) or immediate
  - Register addresses use the low 3 bits of each field.
- Opcodes and controls:
  - 0x00 loadi: FWD, IMM_SEL=1, write rd
  - 0x01 mov: FWD, read rs, write rd
  - 0x02 add: ADD, rt+rs, write rd
  - 0x03 sub: ADD, NEG_SEL=1, write rd
  - 0x04 and: AND, write rd
  - 0x05 or: OR, write rd
  - 0x06 j: no write
  - 0x07 beq: ADD with NEG_SEL=1 on rt, rs; no write
- Any other opcode:
  - sets ILLEGAL; the flag clears only on RESET
  - executes as a no-op with PC+4
- FSM states: RST, FETCH, DECODE, EXEC, WB.
  - RST → FETCH: unconditional.
  - FETCH: INSTR_REQ=1. When INSTR_VALID=1 at a rising edge, IR←INSTR and the FSM goes to DECODE. Otherwise it stays in FETCH, with no timeout.
  - DECODE → EXEC: address, ALUOP, IMMEDIATE and select outputs become valid from IR. They are held stable through EXEC and WB.
  - EXEC → WB: this one-cycle state covers the register-file read delay and the ALU delay. ZERO is captured at the EXEC→WB edge.
  - WB → FETCH: WRITE=1 for this cycle only, and only for write-type opcodes. PC updates on the WB→FETCH edge.
- PC update rules:
  - default: PC+4
  - j: PC+4+(sext(offset)<<2)
  - beq with captured ZERO=1: same as j
  - beq with ZERO=0: PC+4
- PC arithmetic is modulo 2^32; wrap-around is silent.
- INSTR_VALID outside FETCH is ignored.
- WRITE is never asserted outside WB.

## Timing
- RESET is sampled on the rising edge of CLK. On the cycle after RESET is seen, outputs are:
  - PC=0, INSTR_REQ=0, WRITE=0
  - all addresses 0, ALUOP=000, IMMEDIATE=0
  - IMM_SEL=0, NEG_SEL=0, ILLEGAL=0
  - state RST
- Reset mid-instruction: the instruction is abandoned, no WRITE is issued, and PC returns to 0.
- RESET held high keeps the FSM in RST.
- All outputs are registered and change only on rising CLK edges.
- Latency per instruction is 4 cycles (FETCH, DECODE, EXEC, WB) when INSTR_VALID is high on the first FETCH cycle.
- Each cycle of INSTR_VALID low adds one cycle.
- The first FETCH after reset deasserts occurs 1 cycle after leaving RST.
- PC is stable from FETCH through WB of the same instruction.

## Test plan
- Reset then fetch: RESET high 2 cycles, then low, INSTR_VALID=1 with loadi r3,0x2A (0x0003002A). Required:
  - PC=0 during fetch
  - INADDRESS=3, IMMEDIATE=0x2A, IMM_SEL=1, ALUOP=000
  - WRITE pulses exactly once in WB
  - next fetch at PC=4
- Stalled fetch: hold INSTR_VALID=0 for 5 cycles in FETCH, then present add r1,r2,r4 (0x02010204). Required:
  - INSTR_REQ stays high throughout
  - OUT1ADDRESS=2, OUT2ADDRESS=4, INADDRESS=1, ALUOP=001
  - total 9 cycles to the next FETCH
- Branch: beq −2,r1,r2 (0x07FE0102) at PC=0x10.
  - ZERO=1 in EXEC → next PC=0x0C
  - repeat with ZERO=0 → next PC=0x14
  - no WRITE in either case
- Jump wrap: j +1 at PC=0xFFFFFFFC → next PC=0x00000004. sub (0x03...) → NEG_SEL=1, ALUOP=001.
- Illegal and reset: opcode 0xFF → ILLEGAL=1, no WRITE, PC+4. ILLEGAL stays set over following legal instructions. Asserting RESET during EXEC of add → no WRITE, PC=0, ILLEGAL=0.
